// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback
// requesters, plus a 32-entry pending-write scoreboard for decode stalls.
module regfile_wb_arbiter #(
  parameter int NREQ   = 3,
  parameter int DWIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [NREQ-1:0]        req_valid_i,
  input  logic [5*NREQ-1:0]      req_rd_i,
  input  logic [DWIDTH*NREQ-1:0] req_data_i,
  output logic [NREQ-1:0]        req_ready_o,
  output logic [4:0]             rd_o,
  output logic                   regwren_o,
  output logic [DWIDTH-1:0]      datawb_o,
  input  logic                   claim_valid_i,
  input  logic [4:0]             claim_rd_i,
  input  logic                   flush_i,
  output logic [31:0]            busy_o,
  output logic                   claim_err_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]     r_ptr;
  logic [4:0]        r_rd;
  logic              r_wen;
  logic [DWIDTH-1:0] r_data;
  logic [31:0]       r_busy;
  logic              r_err;

  logic [NREQ-1:0]   w_gnt;
  logic              w_hs;
  logic [PW-1:0]     w_gidx;
  logic [4:0]        w_grd;
  logic [DWIDTH-1:0] w_gdata;
  logic              w_claim;
  logic              w_commit;
  logic              w_err_set;
  logic [31:0]       w_busy_nxt;

  function automatic int wrap(input int a);
    return a % NREQ;
  endfunction

  // Handshake: requester k transfers in a cycle where req_valid_i[k] & req_ready_o[k];
  // the register file never stalls, so the first valid requester from r_ptr is always granted.
  always_comb begin
    w_gnt   = '0;
    w_hs    = 1'b0;
    w_gidx  = '0;
    w_grd   = '0;
    w_gdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_hs && req_valid_i[wrap(int'(r_ptr) + i)]) begin
        w_hs                            = 1'b1;
        w_gnt[wrap(int'(r_ptr) + i)]    = 1'b1;
        w_gidx                          = PW'(wrap(int'(r_ptr) + i));
        w_grd                           = req_rd_i[5*wrap(int'(r_ptr) + i) +: 5];
        w_gdata                         = req_data_i[DWIDTH*wrap(int'(r_ptr) + i) +: DWIDTH];
      end
    end
  end

  // Priority within one cycle: commit clear, then claim set, then flush wipes all.
  always_comb begin
    w_claim    = claim_valid_i && (claim_rd_i != 5'd0);
    w_commit   = w_hs && (w_grd != 5'd0);
    w_err_set  = w_claim && r_busy[claim_rd_i] && !(w_commit && (w_grd == claim_rd_i));
    w_busy_nxt = r_busy;
    if (w_commit) w_busy_nxt[w_grd] = 1'b0;
    if (w_claim)  w_busy_nxt[claim_rd_i] = 1'b1;
    if (flush_i)  w_busy_nxt = '0;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_ptr  <= '0;
      r_rd   <= '0;
      r_wen  <= 1'b0;
      r_data <= '0;
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      r_wen <= w_commit;
      if (w_hs) begin
        r_ptr  <= PW'(wrap(int'(w_gidx) + 1));
        r_rd   <= w_grd;
        r_data <= w_gdata;
      end
      r_busy <= w_busy_nxt;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign req_ready_o = reset_i ? w_gnt : '0;
  assign rd_o        = r_rd;
  assign regwren_o   = r_wen;
  assign datawb_o    = r_data;
  assign busy_o      = r_busy;
  assign claim_err_o = r_err;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: vector table, hand sequences for scoreboard/reset
// corner cases, and randomized traffic against a queue-based reference model.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 32;

  logic                clk_i = 1'b0;
  logic                reset_i = 1'b0;
  logic [NREQ-1:0]     req_valid_i;
  logic [5*NREQ-1:0]   req_rd_i;
  logic [DW*NREQ-1:0]  req_data_i;
  logic [NREQ-1:0]     req_ready_o;
  logic [4:0]          rd_o;
  logic                regwren_o;
  logic [DW-1:0]       datawb_o;
  logic                claim_valid_i;
  logic [4:0]          claim_rd_i;
  logic                flush_i;
  logic [31:0]         busy_o;
  logic                claim_err_o;

  int checks = 0;
  int failures = 0;

  // ---------------- clock / DUT ----------------
  always #5 clk_i = ~clk_i;

  regfile_wb_arbiter #(.NREQ(NREQ), .DWIDTH(DW)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_rd_i(req_rd_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .rd_o(rd_o), .regwren_o(regwren_o), .datawb_o(datawb_o),
    .claim_valid_i(claim_valid_i), .claim_rd_i(claim_rd_i), .flush_i(flush_i),
    .busy_o(busy_o), .claim_err_o(claim_err_o)
  );

  // ---------------- reference model ----------------
  int          order[$];      // requester ids in current priority order
  logic [31:0] m_busy;
  logic        m_err;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  int          m_last_g;
  logic [37:0] exp_q[$];      // {regwren, rd, data} expected after each cycle

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    foreach (order[k]) if (req_valid_i[order[k]]) return order[k];
    return -1;
  endfunction

  task automatic model_reset();
    order.delete();
    for (int k = 0; k < NREQ; k++) order.push_back(k);
    m_busy = '0;
    m_err  = 1'b0;
    m_rd   = '0;
    m_data = '0;
    exp_q.delete();
    exp_q.push_back(38'd0);
  endtask

  // Called at posedge+1 with inputs applied; checks at negedge, advances model, returns at posedge+1.
  task automatic step();
    int g;
    int x;
    logic [NREQ-1:0] er;
    logic [37:0] e;
    logic [4:0]  grd;
    logic [31:0] gdata;
    logic [31:0] nb;
    @(negedge clk_i);
    g  = model_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    check("ready", 64'(req_ready_o), 64'(er));
    if (exp_q.size() == 0) begin
      check("exp_q_underflow", 64'(1), 64'(0));
      e = '0;
    end else e = exp_q.pop_front();
    check("regwren", 64'(regwren_o), 64'(e[37]));
    check("rd", 64'(rd_o), 64'(e[36:32]));
    check("datawb", 64'(datawb_o), 64'(e[31:0]));
    check("busy", 64'(busy_o), 64'(m_busy));
    check("claim_err", 64'(claim_err_o), 64'(m_err));
    nb  = m_busy;
    grd = '0;
    if (g >= 0) begin
      grd    = req_rd_i[5*g +: 5];
      gdata  = req_data_i[DW*g +: DW];
      do begin
        x = order.pop_front();
        order.push_back(x);
      end while (x != g);
      if (grd != 5'd0) nb[grd] = 1'b0;
      m_rd   = grd;
      m_data = gdata;
      exp_q.push_back({grd != 5'd0, grd, gdata});
    end else begin
      exp_q.push_back({1'b0, m_rd, m_data});
    end
    if (claim_valid_i && claim_rd_i != 5'd0) begin
      if (m_busy[claim_rd_i] && !(g >= 0 && grd == claim_rd_i)) m_err = 1'b1;
      nb[claim_rd_i] = 1'b1;
    end
    if (flush_i) nb = '0;
    m_busy   = nb;
    m_last_g = g;
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [NREQ-1:0] v, input logic [5*NREQ-1:0] rds,
                       input logic [DW*NREQ-1:0] ds, input logic cv, input logic [4:0] crd,
                       input logic fl);
    req_valid_i   = v;
    req_rd_i      = rds;
    req_data_i    = ds;
    claim_valid_i = cv;
    claim_rd_i    = crd;
    flush_i       = fl;
  endtask

  task automatic idle();
    drive('0, '0, '0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic apply_reset();
    drive('1, '0, '0, 1'b0, 5'd0, 1'b0);
    reset_i = 1'b0;
    #2;
    check("rst_ready", 64'(req_ready_o), 64'(0));
    check("rst_regwren", 64'(regwren_o), 64'(0));
    check("rst_rd", 64'(rd_o), 64'(0));
    check("rst_data", 64'(datawb_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_err", 64'(claim_err_o), 64'(0));
    repeat (2) @(posedge clk_i);
    #1;
    idle();
    reset_i = 1'b1;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NREQ-1:0]    valid;
    logic [5*NREQ-1:0]  rds;
    logic [DW*NREQ-1:0] datas;
    logic [NREQ-1:0]    exp_ready;
    logic               exp_wen;
    logic [4:0]         exp_rd;
    logic [31:0]        exp_data;
  } vec_t;

  function automatic vec_t mk(input logic [NREQ-1:0] v, input logic [4:0] r0, input logic [4:0] r1,
                              input logic [4:0] r2, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [NREQ-1:0] er, input logic ew,
                              input logic [4:0] erd, input logic [31:0] ed);
    vec_t t;
    t.valid = v; t.rds = {r2, r1, r0}; t.datas = {d2, d1, d0};
    t.exp_ready = er; t.exp_wen = ew; t.exp_rd = erd; t.exp_data = ed;
    return t;
  endfunction

  vec_t vec[16];

  // ---------------- scoreboard / stimulus ----------------
  logic [NREQ-1:0] rv;
  logic [4:0]      rrd [NREQ];
  logic [31:0]     rdat[NREQ];

  initial begin
    idle();
    vec[0]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b001, 1'b1, 5'd1, 32'h11);
    vec[1]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b010, 1'b1, 5'd2, 32'h22);
    vec[2]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b100, 1'b1, 5'd3, 32'h33);
    vec[3]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b001, 1'b1, 5'd1, 32'h11);
    vec[4]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b010, 1'b1, 5'd2, 32'h22);
    vec[5]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b100, 1'b1, 5'd3, 32'h33);
    vec[6]  = mk(3'b011, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b001, 1'b1, 5'd1, 32'h11);
    vec[7]  = mk(3'b010, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b010, 1'b1, 5'd2, 32'h22);
    vec[8]  = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd2, 32'h22);
    vec[9]  = mk(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 3'b001, 1'b1, 5'd5, 32'hDEADBEEF);
    vec[10] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd5, 32'hDEADBEEF);
    vec[11] = mk(3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'h1234, 32'h0, 3'b010, 1'b0, 5'd0, 32'h1234);
    vec[12] = mk(3'b011, 5'd10, 5'd11, 5'd0, 32'hAA, 32'hBB, 32'h0, 3'b001, 1'b1, 5'd10, 32'hAA);
    vec[13] = mk(3'b110, 5'd0, 5'd11, 5'd13, 32'h0, 32'hBB, 32'hDD, 3'b010, 1'b1, 5'd11, 32'hBB);
    vec[14] = mk(3'b100, 5'd0, 5'd0, 5'd13, 32'h0, 32'h0, 32'hDD, 3'b100, 1'b1, 5'd13, 32'hDD);
    vec[15] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd13, 32'hDD);

    #1;
    apply_reset();
    for (int c = 0; c < 10; c++) step();

    // table: fairness, single write, x0 write, mixed grants
    for (int i = 0; i < 16; i++) begin
      drive(vec[i].valid, vec[i].rds, vec[i].datas, 1'b0, 5'd0, 1'b0);
      #1;
      check($sformatf("vec%0d_ready", i), 64'(req_ready_o), 64'(vec[i].exp_ready));
      step();
      check($sformatf("vec%0d_wen", i), 64'(regwren_o), 64'(vec[i].exp_wen));
      check($sformatf("vec%0d_rd", i), 64'(rd_o), 64'(vec[i].exp_rd));
      check($sformatf("vec%0d_data", i), 64'(datawb_o), 64'(vec[i].exp_data));
    end

    // scoreboard sequence
    apply_reset();
    drive('0, '0, '0, 1'b1, 5'd7, 1'b0); step();
    check("claim7_busy", 64'(busy_o[7]), 64'(1));
    idle(); step(); step();
    drive(3'b010, {5'd0, 5'd7, 5'd0}, {32'h0, 32'h77, 32'h0}, 1'b0, 5'd0, 1'b0); step();
    check("commit7_busy", 64'(busy_o[7]), 64'(0));
    check("commit7_wen", 64'(regwren_o), 64'(1));
    drive('0, '0, '0, 1'b1, 5'd0, 1'b0); step();
    check("claim0_busy", 64'(busy_o), 64'(0));
    drive('0, '0, '0, 1'b1, 5'd4, 1'b0); step();
    drive(3'b100, {5'd4, 5'd0, 5'd0}, {32'h44, 32'h0, 32'h0}, 1'b1, 5'd4, 1'b0); step();
    check("claim_commit4_busy", 64'(busy_o[4]), 64'(1));
    check("claim_commit4_err", 64'(claim_err_o), 64'(0));
    drive('0, '0, '0, 1'b1, 5'd9, 1'b0); step(); step();
    check("claim9_twice_err", 64'(claim_err_o), 64'(1));
    idle(); step();
    check("err_sticky", 64'(claim_err_o), 64'(1));
    drive('0, '0, '0, 1'b1, 5'd6, 1'b1); step();
    check("flush_claim6_busy", 64'(busy_o), 64'(0));

    // async reset while a write is in the output stage
    drive(3'b001, {5'd0, 5'd0, 5'd3}, {32'h0, 32'h0, 32'h55}, 1'b1, 5'd8, 1'b0); step();
    check("pre_reset_wen", 64'(regwren_o), 64'(1));
    apply_reset();
    drive(3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1}, 1'b0, 5'd0, 1'b0);
    #1;
    check("post_reset_first_grant", 64'(req_ready_o), 64'(3'b001));
    step();

    // randomized traffic against the model
    for (int round = 0; round < 3; round++) begin
      apply_reset();
      rv = '0;
      for (int k = 0; k < NREQ; k++) begin rrd[k] = '0; rdat[k] = '0; end
      for (int c = 0; c < 600; c++) begin
        for (int k = 0; k < NREQ; k++) begin
          if (!rv[k] && $urandom_range(0, 1) == 1) begin
            rv[k]   = 1'b1;
            rrd[k]  = 5'($urandom_range(0, 31));
            rdat[k] = $urandom;
          end
        end
        drive(rv, {rrd[2], rrd[1], rrd[0]}, {rdat[2], rdat[1], rdat[0]},
              $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)), $urandom_range(0, 49) == 0);
        step();
        if (m_last_g >= 0) rv[m_last_g] = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
